// File: rtl/mips_multicycle_if.sv
// mips_multicycle_if: unified instruction/data memory port for mips_multicycle.
// One request at a time; an access completes at the clock edge where req & ready.
//   req    master->slave  access request, held until completion
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  word address (ADDR_W bits)
//   wdata  master->slave  store data
//   rdata  slave->master  read data, valid in the cycle ready=1
//   ready  slave->master  completes the pending access
interface mips_multicycle_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ready;

   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS-I subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with its own
// 32x32 register file and ALU, sharing one req/ready memory port for fetches and data.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   mem     unified memory port (master side of mips_multicycle_if)
//   pc_o    current PC (debug)
//   halted  sticky, set when an illegal opcode/funct is decoded; cleared only by reset
// Optional feature: define MIPS_MC_EXT_ISA_EN to add slt, bne, jal and jr; without it those
// encodings are illegal and halt the core.
module mips_multicycle #(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst,
   mips_multicycle_if.master        mem,
   output logic [31:0]              pc_o,
   output logic                     halted
);

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpLui   = 6'h0F;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] FnAddu  = 6'h21;
   localparam logic [5:0] FnSubu  = 6'h23;
   localparam logic [5:0] FnAnd   = 6'h24;
   localparam logic [5:0] FnOr    = 6'h25;
`ifdef MIPS_MC_EXT_ISA_EN
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnSlt   = 6'h2A;
`endif

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
   logic        halted_q, halted_d;
   logic [31:0] rf_q [32];

   logic              req, we, legal, rf_we;
   logic [ADDR_W-1:0] addr;
   logic [4:0]        rf_waddr;
   logic [31:0]       rf_wdata, r_res;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] sext_imm;
   logic        unused_shamt;

   assign op           = ir_q[31:26];
   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign funct        = ir_q[5:0];
   assign imm          = ir_q[15:0];
   assign sext_imm     = {{16{imm[15]}}, imm};
   assign unused_shamt = ^ir_q[10:6];

   always_comb begin
      legal = 1'b0;
      case (op)
         OpRtype: begin
            case (funct)
               FnAddu, FnSubu, FnAnd, FnOr: legal = 1'b1;
`ifdef MIPS_MC_EXT_ISA_EN
               FnSlt, FnJr:                 legal = 1'b1;
`endif
               default:                     legal = 1'b0;
            endcase
         end
         OpJ, OpBeq, OpOri, OpLui, OpLw, OpSw: legal = 1'b1;
`ifdef MIPS_MC_EXT_ISA_EN
         OpJal, OpBne:                         legal = 1'b1;
`endif
         default:                              legal = 1'b0;
      endcase
   end

   always_comb begin
      r_res = '0;
      case (funct)
         FnAddu:  r_res = a_q + b_q;
         FnSubu:  r_res = a_q - b_q;
         FnAnd:   r_res = a_q & b_q;
         FnOr:    r_res = a_q | b_q;
`ifdef MIPS_MC_EXT_ISA_EN
         FnSlt:   r_res = {31'b0, $signed(a_q) < $signed(b_q)};
`endif
         default: r_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      halted_d = halted_q;
      req      = 1'b0;
      we       = 1'b0;
      addr     = pc_q[ADDR_W+1:2];
      rf_we    = 1'b0;
      rf_waddr = rt;
      rf_wdata = alu_q;
      unique case (state_q)
         StFetch: begin
            req = 1'b1;
            if (mem.ready) begin
               ir_d    = mem.rdata;
               pc_d    = pc_q + 32'd4;
               state_d = StDecode;
            end
         end
         StDecode: begin
            a_d   = rf_q[rs];
            b_d   = rf_q[rt];
            // Branch target precomputed here; pc_q already points at the next instruction.
            alu_d = pc_q + {sext_imm[29:0], 2'b00};
            if (legal) begin
               state_d = StExec;
            end else begin
               state_d  = StHalt;
               halted_d = 1'b1;
            end
         end
         StExec: begin
            state_d = StFetch;
            case (op)
               OpRtype: begin
`ifdef MIPS_MC_EXT_ISA_EN
                  if (funct == FnJr) begin
                     pc_d = a_q;
                  end else begin
                     alu_d   = r_res;
                     state_d = StWb;
                  end
`else
                  alu_d   = r_res;
                  state_d = StWb;
`endif
               end
               OpOri: begin
                  alu_d   = a_q | {16'h0, imm};
                  state_d = StWb;
               end
               OpLui: begin
                  alu_d   = {imm, 16'h0};
                  state_d = StWb;
               end
               OpLw, OpSw: begin
                  alu_d   = a_q + sext_imm;
                  state_d = StMem;
               end
               OpBeq: if (a_q == b_q) pc_d = alu_q;
               OpJ:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
`ifdef MIPS_MC_EXT_ISA_EN
               OpBne: if (a_q != b_q) pc_d = alu_q;
               OpJal: begin
                  // Link write happens in EXEC; pc_q already holds the return address.
                  rf_we    = 1'b1;
                  rf_waddr = 5'd31;
                  rf_wdata = pc_q;
                  pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
               end
`endif
               default: state_d = StHalt;
            endcase
         end
         StMem: begin
            req  = 1'b1;
            we   = (op == OpSw);
            addr = alu_q[ADDR_W+1:2];
            if (mem.ready) begin
               if (op == OpSw) begin
                  state_d = StFetch;
               end else begin
                  mdr_d   = mem.rdata;
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            rf_we    = 1'b1;
            rf_waddr = (op == OpRtype) ? rd : rt;
            rf_wdata = (op == OpLw) ? mdr_q : alu_q;
            state_d  = StFetch;
         end
         StHalt:  halted_d = 1'b1;
         default: state_d  = StHalt;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
         halted_q <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         alu_q    <= alu_d;
         mdr_q    <= mdr_d;
         halted_q <= halted_d;
         if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
      end
   end

   // Request is gated by reset so an in-flight access is abandoned immediately.
   assign mem.req   = req & ~rst;
   assign mem.we    = we;
   assign mem.addr  = addr;
   assign mem.wdata = b_q;
   assign pc_o      = pc_q;
   assign halted    = halted_q;

endmodule
